// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: requester IDs, FSM encoding, default RAM latency.
package ram_arb_pkg;

   localparam int unsigned DEF_RAM_LAT = 1;

   localparam int unsigned REQ_CPU     = 0;
   localparam int unsigned REQ_EXTCALL = 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: packed per-requester commands, grants and read returns.
interface ram_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 12,
   parameter int unsigned DW   = 18
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_we;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   modport master (
      output req, req_we, req_lock, req_addr, req_wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, req_we, req_lock, req_addr, req_wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW-1:0] cand;

   function automatic logic [IW-1:0] wrap(input int unsigned v);
      return IW'(v % NREQ);
   endfunction

   always_comb begin
      win  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = wrap(32'(ptr) + k);
         if (!any && req[cand]) begin
            win[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters, with lockable
// atomic sequences and a fixed-latency read-return pipe steering rvalid to the issuer.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned AW      = 12,
   parameter int unsigned DW      = 18,
   parameter int unsigned RAM_LAT = DEF_RAM_LAT
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_arbiter_if.slave        bus,
   output logic                ram_en,
   output logic                ram_we,
   output logic [AW-1:0]       ram_addr,
   output logic [DW-1:0]       ram_wdata,
   input  logic [DW-1:0]       ram_rdata
);

   localparam int unsigned IW = id_width(NREQ);

   typedef struct packed {
      logic          rd;
      logic [IW-1:0] id;
   } resp_t;

   logic [0:0]      state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] owner_oh, elig, win;
   logic [IW-1:0]   idx;
   logic            any, granted;
   resp_t           pipe_q [RAM_LAT];

   // While locked only the owner is eligible; the pointer is then irrelevant.
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      elig = (state_q == ST_LOCKED) ? (bus.req & owner_oh) : bus.req;
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req  (elig),
      .ptr  (ptr_q),
      .win  (win),
      .idx  (idx),
      .any  (any)
   );

   // Outputs are forced quiet while reset is held, even with requests pending.
   assign granted   = any & rst_n;
   assign bus.gnt   = win & {NREQ{rst_n}};
   assign ram_en    = granted;
   assign ram_we    = granted & bus.req_we[idx];
   assign ram_addr  = granted ? bus.req_addr[32'(idx)*AW +: AW] : '0;
   assign ram_wdata = granted ? bus.req_wdata[32'(idx)*DW +: DW] : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (any) begin
         if (state_q == ST_IDLE) begin
            ptr_d = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (bus.req_lock[idx]) begin
               state_d = ST_LOCKED;
               owner_d = idx;
            end
         end else if (!bus.req_lock[idx]) begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < RAM_LAT; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pipe_q[0] <= '{rd: any & ~bus.req_we[idx], id: idx};
         for (int unsigned k = 1; k < RAM_LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   always_comb begin
      bus.rvalid = '0;
      if (pipe_q[RAM_LAT-1].rd) begin
         bus.rvalid[pipe_q[RAM_LAT-1].id] = 1'b1;
      end
   end

   assign bus.rdata = ram_rdata;

endmodule
